// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the 3x3 Sobel edge filter.
// Holds the output mode encoding, the luma weights and the row counter width.
package conv_pkg;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_MAG    = 2'd1,
    MODE_BIN    = 2'd2,
    MODE_LUMA   = 2'd3
  } mode_e;
  localparam logic [7:0] LUMA_R = 8'd54;
  localparam logic [7:0] LUMA_G = 8'd183;
  localparam logic [7:0] LUMA_B = 8'd18;
  localparam int LUMA_SHIFT = 8;
  localparam int ROW_W = 12;
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: two cascaded line RAMs addressed by column.
// Ports: clk; we writes wdata into line 0 and shifts line 0 into line 1 at addr;
// rd0/rd1 are the combinational line 0/line 1 contents at addr before the write.
// The RAMs carry no reset: stale contents are masked downstream by the border rule.
module conv_line_buf #(
  parameter int DEPTH = 640,
  parameter int DW    = 24,
  parameter int ADR_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADR_W-1:0] addr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rd0,
  output logic [DW-1:0]    rd1
);
  logic [DW-1:0] line0_q [DEPTH];
  logic [DW-1:0] line1_q [DEPTH];
  assign rd0 = line0_q[addr];
  assign rd1 = line1_q[addr];
  always_ff @(posedge clk)
    if (we) begin
      line0_q[addr] <= wdata;
      line1_q[addr] <= rd0;
    end
endmodule

// File: rtl/conv3x3_edge_filter.sv
// conv3x3_edge_filter: streaming 3x3 Sobel edge filter on RGB video.
// Ports: clk, rst_n (async, active low); in_valid/in_sof/in_rgb pixel stream;
// mode selects out_rgb (bypass/magnitude/binary/luma); thresh is the noise floor;
// out_valid/out_sof/out_edge/out_rgb follow each input pixel by exactly 3 clocks.
module conv3x3_edge_filter
  import conv_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8,
  parameter int ADR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [3*PIX_W-1:0] in_rgb,
  input  logic [1:0]         mode,
  input  logic [PIX_W-1:0]   thresh,
  output logic               out_valid,
  output logic               out_sof,
  output logic [PIX_W-1:0]   out_edge,
  output logic [3*PIX_W-1:0] out_rgb
);
  localparam int DW = 3*PIX_W;
  localparam int GW = PIX_W+3;
  localparam int SW = PIX_W+4;

  function automatic logic [PIX_W-1:0] luma(input logic [DW-1:0] p);
    logic [PIX_W+7:0] s;
    s = LUMA_R*p[DW-1 -: PIX_W] + LUMA_G*p[2*PIX_W-1 -: PIX_W] + LUMA_B*p[PIX_W-1:0];
    return s[PIX_W+7:LUMA_SHIFT];
  endfunction

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] x);
    return $signed({3'b000, x});
  endfunction

  logic [ADR_W-1:0] col_q, col_d, pcol;
  logic [ROW_W-1:0] row_q, row_d, prow;
  logic wrap;
  logic [DW-1:0] lb0, lb1;
  logic [8:0][DW-1:0] win_q, win_d;
  logic [8:0][PIX_W-1:0] l;
  logic v1_q, v1_d, sof1_q, sof1_d, bord1_q, bord1_d;
  logic v2_q, v2_d, sof2_q, sof2_d, bord2_q, bord2_d;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [GW-1:0] ax, ay;
  logic [SW-1:0] sum;
  logic [PIX_W-1:0] sat, mag;
  logic [DW-1:0] ctr_q, ctr_d;
  logic [PIX_W-1:0] lc_q, lc_d;
  logic out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [PIX_W-1:0] edge_q, edge_d;
  logic [DW-1:0] rgb_q, rgb_d;

  conv_line_buf #(.DEPTH(IMG_W), .DW(DW), .ADR_W(ADR_W)) u_lb (
    .clk(clk), .we(in_valid), .addr(pcol), .wdata(in_rgb), .rd0(lb0), .rd1(lb1)
  );

  always_comb begin
    // A start-of-frame pixel is itself (0,0), so it also addresses column 0.
    pcol = in_sof ? '0 : col_q;
    prow = in_sof ? '0 : row_q;
    wrap = pcol == ADR_W'(IMG_W-1);
    col_d = in_valid ? (wrap ? '0 : pcol + 1'b1) : col_q;
    row_d = in_valid ? (wrap && prow != '1 ? prow + 1'b1 : prow) : row_q;
    // Each row shifts left; p2/p5/p8 take line1, line0 and the live pixel.
    win_d = in_valid ? {in_rgb, win_q[8:7], lb0, win_q[5:4], lb1, win_q[2:1]} : win_q;
    bord1_d = in_valid ? (prow < ROW_W'(2) || pcol < ADR_W'(2)) : bord1_q;
    v1_d = in_valid;
    sof1_d = in_valid & in_sof;
    for (int i = 0; i < 9; i++) l[i] = luma(win_q[i]);
    gx_d = ext(l[2]) - ext(l[0]) + ((ext(l[5]) - ext(l[3])) <<< 1) + ext(l[8]) - ext(l[6]);
    gy_d = ext(l[0]) - ext(l[6]) + ((ext(l[1]) - ext(l[7])) <<< 1) + ext(l[2]) - ext(l[8]);
    v2_d = v1_q;
    sof2_d = sof1_q;
    bord2_d = bord1_q;
    ctr_d = win_q[4];
    lc_d = l[4];
    ax = gx_q[GW-1] ? -gx_q : gx_q;
    ay = gy_q[GW-1] ? -gy_q : gy_q;
    sum = SW'(ax) + SW'(ay);
    sat = |sum[SW-1:PIX_W] ? '1 : sum[PIX_W-1:0];
    mag = (bord2_q || sat <= thresh) ? '0 : sat;
    out_valid_d = v2_q;
    out_sof_d = sof2_q;
    edge_d = v2_q ? mag : edge_q;
    rgb_d = !v2_q ? rgb_q :
            mode == MODE_BYPASS ? ctr_q :
            mode == MODE_MAG    ? {3{mag}} :
            mode == MODE_BIN    ? {DW{|mag}} : {3{lc_q}};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      v1_q <= 1'b0;
      sof1_q <= 1'b0;
      bord1_q <= 1'b0;
      v2_q <= 1'b0;
      sof2_q <= 1'b0;
      bord2_q <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
      ctr_q <= '0;
      lc_q <= '0;
      out_valid_q <= 1'b0;
      out_sof_q <= 1'b0;
      edge_q <= '0;
      rgb_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      v1_q <= v1_d;
      sof1_q <= sof1_d;
      bord1_q <= bord1_d;
      v2_q <= v2_d;
      sof2_q <= sof2_d;
      bord2_q <= bord2_d;
      gx_q <= gx_d;
      gy_q <= gy_d;
      ctr_q <= ctr_d;
      lc_q <= lc_d;
      out_valid_q <= out_valid_d;
      out_sof_q <= out_sof_d;
      edge_q <= edge_d;
      rgb_q <= rgb_d;
    end

  assign out_valid = out_valid_q;
  assign out_sof = out_sof_q;
  assign out_edge = edge_q;
  assign out_rgb = rgb_q;
endmodule

// File: tb/tb_conv3x3_edge_filter.sv
// tb_conv3x3_edge_filter: directed + random checks of the Sobel filter against an image-level model.
module tb_conv3x3_edge_filter;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [23:0] in_rgb = '0;
  logic [1:0] mode = 2'd0;
  logic [7:0] thresh = '0;
  logic out_valid, out_sof;
  logic [7:0] out_edge;
  logic [23:0] out_rgb;

  conv3x3_edge_filter #(.IMG_W(W), .PIX_W(8), .ADR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_rgb(in_rgb),
    .mode(mode), .thresh(thresh), .out_valid(out_valid), .out_sof(out_sof),
    .out_edge(out_edge), .out_rgb(out_rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit bord;
    logic [7:0] sat;
    logic [23:0] ctr;
    bit sof;
  } exp_t;

  exp_t q[$];
  int cyc = 0, nvec = 0, nerr = 0, mr = 0, mc = 0;
  bit rand_ctl = 0;
  logic [23:0] frame [16][W];
  logic [7:0] last_edge = '0;

  function automatic logic [7:0] lum(input logic [23:0] p);
    int s;
    s = 54*p[23:16] + 183*p[15:8] + 18*p[7:0];
    return 8'(s / 256);
  endfunction

  function automatic int L(input int r, input int c);
    return int'(lum(frame[r % 16][c]));
  endfunction

  function automatic logic [23:0] pat(input int kind, input int c);
    if (kind == 0) return 24'h808080;
    if (kind == 1) return c >= 4 ? 24'hFFFFFF : 24'h000000;
    if (kind == 2) return c >= 4 ? 24'h040404 : 24'h000000;
    return 24'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic tick();
    exp_t x;
    logic [7:0] e;
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      x = q.pop_front();
      e = (x.bord || x.sat <= thresh) ? 8'd0 : x.sat;
      chk("valid", 32'(out_valid), 32'd1);
      chk("sof", 32'(out_sof), 32'(x.sof));
      chk("edge", 32'(out_edge), 32'(e));
      if (mode == 2'd1) chk("rgb_mag", 32'(out_rgb), 32'({3{e}}));
      else if (mode == 2'd2) chk("rgb_bin", 32'(out_rgb), e != 0 ? 32'hFFFFFF : 32'h0);
      else if (!x.bord) chk(mode == 2'd0 ? "rgb_bypass" : "rgb_luma", 32'(out_rgb),
                            mode == 2'd0 ? 32'(x.ctr) : 32'({3{lum(x.ctr)}}));
      last_edge = e;
    end else begin
      chk("valid_idle", 32'(out_valid), 32'd0);
      chk("sof_idle", 32'(out_sof), 32'd0);
      chk("edge_hold", 32'(out_edge), 32'(last_edge));
    end
  endtask

  task automatic pix(input bit sof, input logic [23:0] rgb);
    exp_t x;
    int pr, pc, gx, gy, ax, ay;
    in_valid = 1'b1;
    in_sof = sof;
    in_rgb = rgb;
    if (rand_ctl) begin
      mode = 2'($urandom);
      thresh = 8'($urandom_range(0, 60));
    end
    pr = sof ? 0 : mr;
    pc = sof ? 0 : mc;
    frame[pr % 16][pc] = rgb;
    x.due = cyc + 3;
    x.sof = sof;
    x.bord = pr < 2 || pc < 2;
    x.sat = '0;
    x.ctr = '0;
    if (!x.bord) begin
      gx = L(pr-2, pc) - L(pr-2, pc-2) + 2*(L(pr-1, pc) - L(pr-1, pc-2)) + L(pr, pc) - L(pr, pc-2);
      gy = L(pr-2, pc-2) - L(pr, pc-2) + 2*(L(pr-2, pc-1) - L(pr, pc-1)) + L(pr-2, pc) - L(pr, pc);
      ax = gx < 0 ? -gx : gx;
      ay = gy < 0 ? -gy : gy;
      x.sat = 8'((ax + ay) > 255 ? 255 : ax + ay);
      x.ctr = frame[(pr-1) % 16][pc-1];
    end
    q.push_back(x);
    mc = pc + 1;
    mr = pr;
    if (mc == W) begin
      mc = 0;
      mr = pr < 4095 ? pr + 1 : pr;
    end
    tick();
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_rgb = 24'($urandom);
    if (rand_ctl) begin
      mode = 2'($urandom);
      thresh = 8'($urandom_range(0, 60));
    end
    tick();
  endtask

  task automatic drain();
    repeat (4) idle();
  endtask

  task automatic frame_run(input int rows, input int kind, input int maxgap);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++) begin
        pix(r == 0 && c == 0, pat(kind, c));
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) idle();
      end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_rgb", 32'(out_rgb), 32'd0);
    rst_n = 1'b1;
    idle();
    mode = 2'd1; thresh = 8'd0;
    frame_run(4, 0, 0);
    drain();
    thresh = 8'd19;
    frame_run(4, 1, 0);
    drain();
    frame_run(3, 2, 0);
    thresh = 8'd10;
    frame_run(3, 2, 0);
    mode = 2'd2;
    frame_run(3, 2, 0);
    drain();
    mode = 2'd1; thresh = 8'd19;
    frame_run(4, 1, 2);
    drain();
    rand_ctl = 1;
    frame_run(5, 3, 2);
    rand_ctl = 0;
    drain();
    mode = 2'd1; thresh = 8'd19;
    frame_run(3, 1, 0);
    for (int c = 0; c < 3; c++) pix(1'b0, pat(1, c));
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sof", 32'(out_sof), 32'd0);
    chk("rst_edge", 32'(out_edge), 32'd0);
    chk("rst_rgb", 32'(out_rgb), 32'd0);
    q.delete();
    last_edge = '0;
    mr = 0; mc = 0;
    tick();
    rst_n = 1'b1;
    frame_run(3, 1, 0);
    drain();
    mode = 2'd0; thresh = 8'($urandom_range(0, 40));
    frame_run(4, 3, 0);
    for (int c = 0; c < 5; c++) pix(1'b0, pat(3, c));
    pix(1'b1, pat(3, 0));
    for (int i = 0; i < 3*W - 1; i++) pix(1'b0, pat(3, 0));
    mode = 2'd3;
    for (int i = 0; i < W; i++) pix(1'b0, pat(3, 0));
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv3x3_edge_filter.md
Name: conv3x3_edge_filter

Overview:
- Parametrised, streaming 3x3 Sobel edge filter for the D8M video path; successor to the fixed 640-pixel, 8-bit Sobel stage.
- Accepts one RGB pixel per qualified clock, keeps two line buffers, and forms a 3x3 luma window.
- Emits, per pixel, an edge magnitude (thresholded, or binary) or the window-centre RGB. Output timing is fixed and valid-qualified.
- Sits between the camera RGB stream and the cartoon/overlay mixer.

Parameters:
- IMG_W, 640, active pixels per line (col counter wraps at IMG_W-1)
- PIX_W, 8, bits per colour channel
- ADR_W, 10, line-buffer address width; must satisfy 2^ADR_W >= IMG_W

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_rgb is a valid pixel this cycle
- in_sof  in  1  with in_valid: this pixel is row 0, col 0 of a frame
- in_rgb  in  3*PIX_W  {R,G,B}
- mode  in  2  0 bypass, 1 magnitude, 2 binary, 3 luma
- thresh  in  PIX_W  noise threshold, sampled every cycle
- out_valid  out  1  out_* valid
- out_sof  out  1  in_sof delayed to match out_valid
- out_edge  out  PIX_W  edge value, mode-independent magnitude (0 on border)
- out_rgb  out  3*PIX_W  mode-selected pixel

Behaviour:
- Reset (async, rst_n=0): col=0, row=0; window registers, valid/sof pipeline and all outputs are 0. Line-buffer RAM is not cleared; stale data is masked by the border rule.
- Counters advance only on in_valid.
  - in_sof&in_valid forces the current pixel to (0,0); the next pixel is col 1.
  - col wraps IMG_W-1 -> 0 and row increments; row saturates at 2^12-1.
- Line buffers: 2 RAMs of IMG_W x 3*PIX_W, addressed by col.
  - On in_valid: line1[col] <= line0[col], line0[col] <= in_rgb.
  - Read-before-write within the same cycle.
- Window: three 3-deep shift registers, advanced only on in_valid. Rows are in_rgb, line0[col] and line1[col]; p0 is oldest row/oldest col, p8 is newest row/newest col.
- Luma per tap: (54R + 183G + 18B) >> 8 on PIX_W-wide channels, PIX_W-bit result.
- Gradient:
  - gx = (p2-p0) + 2(p5-p3) + (p8-p6); gy = (p0-p6) + 2(p1-p7) + (p2-p8).
  - Both signed, PIX_W+3 bits, no overflow possible.
- Magnitude:
  - sum = |gx| + |gy|, PIX_W+4 bits; sat = min(sum, 2^PIX_W-1).
  - mag = (sat <= thresh) ? 0 : sat.
- Border: out_edge = 0 when the counters of the newest window pixel have row<2 or col<2. Output is offset by one row and one column relative to the image; no flush at end of frame.
- Output select:
  - mode 0: out_rgb = window-centre RGB (p4).
  - mode 1: {mag,mag,mag}.
  - mode 2: all-ones in each channel if mag != 0, else 0.
  - mode 3: {luma(p4) x3}.
- Latency: fixed 3 clocks from an in_valid cycle to its out_valid (stages: window load, luma/gradient, abs/sum/threshold/select).
  - Stages advance every clock; no backpressure.
  - out_valid = in_valid delayed 3 clocks; outputs hold their values when out_valid=0.
- in_valid gaps: window and counters freeze; results are identical to a gapless stream.
- mode/thresh changes take effect on the output 1 clock later (sampled in stage 3).
- in_sof mid-line: counters resync immediately; the next two rows are border (edge 0).

Decomposition:
- Package conv_pkg:
  - MODE_BYPASS/MAG/BIN/LUMA constants
  - luma coefficients 54/183/18
  - LUMA_SHIFT=8
- Sub-module conv_line_buf (two RAMs, read-before-write, col addressing).
- Window, gradient and output pipeline stay in the top level.

Test Plan:
- IMG_W=8, constant grey 128 for 4 rows, mode 1 -> out_edge 0 everywhere; out_valid exactly 3 clocks after each in_valid.
- Vertical step: cols 0-3 = 0, cols 4-7 = RGB 255 (luma 254), mode 1, thresh 19 -> rows>=2: edge 255 at input cols 4,5; 0 at cols 2,3,6,7; rows 0-1 all 0.
- Step of 0 vs grey 4 (luma 3, gx=12): thresh 19 -> edge 0; thresh 10 -> edge 12; mode 2 with thresh 10 -> out_rgb 0xFFFFFF at that pixel.
- Repeat the step test with in_valid toggling 1-0-0-1 randomly -> output sequence identical to the gapless run.
- Assert rst_n mid-row 3 for 1 clock -> out_valid 0 at once; after release plus in_sof, rows 0-1 edge 0 and row 2 correct.
- in_sof at col 5 of row 4 -> next pixel reports col 1; edge 0 for the following 2 rows; mode 0 returns the centre RGB delayed to out_valid.
